// File: rtl/rpn_stack_engine_if.sv
// Command handshake bundle between the keypad/command decoder and rpn_stack_engine.
interface rpn_stack_engine_if #(
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_type;
    logic [DW-1:0] cmd_data;
    logic [3:0]    cmd_op;
    logic [4:0]    cmd_shamt;

    modport master (
        output cmd_valid, cmd_type, cmd_data, cmd_op, cmd_shamt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_data, cmd_op, cmd_shamt,
        output cmd_ready
    );
endinterface

// File: rtl/rpn_stack_engine.sv
// RPN operand-stack sequencer feeding the calculator ALU and writing results back.
// Optional MULT_HI_PUSH_EN: multiply ops (0110/0111) also push the high result word.
module rpn_stack_engine #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    rpn_stack_engine_if.slave          cmd,
    output logic [DW-1:0]              alu_a,
    output logic [DW-1:0]              alu_b,
    output logic [3:0]                 alu_op,
    output logic [4:0]                 alu_shamt,
    input  logic [DW-1:0]              alu_hi,
    input  logic [DW-1:0]              alu_lo,
    input  logic                       alu_zero,
    output logic [DW-1:0]              tos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       flag_zero,
    output logic                       err_underflow,
    output logic                       err_overflow
);
    localparam int AW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, WB_HI} state_t;

    state_t        state;
    logic [DW-1:0] stack [DEPTH];
    logic [AW-1:0] depth_r;
    logic          ready_r;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] sec_idx;
    logic [IW-1:0] push_idx;

`ifdef MULT_HI_PUSH_EN
    logic [DW-1:0] hi_q;
`else
    logic          unused_hi;
    assign unused_hi = ^alu_hi;
`endif

    assign top_idx  = IW'(depth_r - AW'(1));
    assign sec_idx  = IW'(depth_r - AW'(2));
    assign push_idx = IW'(depth_r);

    assign tos           = (depth_r == '0) ? '0 : stack[top_idx];
    assign depth         = depth_r;
    assign cmd.cmd_ready = ready_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            depth_r       <= '0;
            ready_r       <= 1'b1;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            alu_shamt     <= '0;
            flag_zero     <= 1'b0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
`ifdef MULT_HI_PUSH_EN
            hi_q          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        case (cmd.cmd_type)
                            2'b00: begin
                                if (depth_r == AW'(DEPTH)) begin
                                    err_overflow <= 1'b1;
                                end else begin
                                    stack[push_idx] <= cmd.cmd_data;
                                    depth_r         <= depth_r + AW'(1);
                                end
                            end
                            2'b01: begin
                                if (depth_r == '0) err_underflow <= 1'b1;
                                else               depth_r       <= depth_r - AW'(1);
                            end
                            2'b10: begin
                                if (depth_r < AW'(2)) begin
                                    err_underflow <= 1'b1;
                                end else begin
                                    alu_a     <= stack[sec_idx];
                                    alu_b     <= stack[top_idx];
                                    alu_op    <= cmd.cmd_op;
                                    alu_shamt <= cmd.cmd_shamt;
                                    state     <= EXEC;
                                    ready_r   <= 1'b0;
                                end
                            end
                            default: begin
                                depth_r       <= '0;
                                err_underflow <= 1'b0;
                                err_overflow  <= 1'b0;
                                flag_zero     <= 1'b0;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    // depth is untouched during EXEC, so sec_idx still names operand a's slot
                    stack[sec_idx] <= alu_lo;
                    flag_zero      <= alu_zero;
`ifdef MULT_HI_PUSH_EN
                    if (alu_op[3:1] == 3'b011) begin
                        hi_q  <= alu_hi;
                        state <= WB_HI;
                    end else begin
                        depth_r <= depth_r - AW'(1);
                        state   <= IDLE;
                        ready_r <= 1'b1;
                    end
`else
                    depth_r <= depth_r - AW'(1);
                    state   <= IDLE;
                    ready_r <= 1'b1;
`endif
                end
                WB_HI: begin
`ifdef MULT_HI_PUSH_EN
                    stack[top_idx] <= hi_q;
`endif
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rpn_stack_engine.sv
// Scoreboard bench for rpn_stack_engine: queue-based stack model, behavioural ALU, randomized commands.
module tb_rpn_stack_engine;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] alu_a, alu_b, alu_hi, alu_lo, tos;
    logic [3:0]    alu_op;
    logic [4:0]    alu_shamt;
    logic          alu_zero;
    logic [AW-1:0] depth;
    logic          flag_zero, err_underflow, err_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rpn_stack_engine_if #(.DW(DW)) cif ();

    rpn_stack_engine #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cmd(cif.slave),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_hi(alu_hi), .alu_lo(alu_lo), .alu_zero(alu_zero),
        .tos(tos), .depth(depth), .flag_zero(flag_zero),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    // Behavioural ALU, also used by the reference model
    function automatic logic [63:0] alu_calc(input logic [3:0] op, input logic [31:0] a, b,
                                             input logic [4:0] sh);
        case (op)
            4'h0:       return {32'h0, a & b};
            4'h1:       return {32'h0, a | b};
            4'h2:       return {32'h0, a ^ b};
            4'h3:       return {32'h0, a << sh};
            4'h4:       return {32'h0, a + b};
            4'h5:       return {32'h0, a - b};
            4'h6, 4'h7: return {32'h0, a} * {32'h0, b};
            default:    return {32'h0, a >> sh};
        endcase
    endfunction

    always_comb begin
        {alu_hi, alu_lo} = alu_calc(alu_op, alu_a, alu_b, alu_shamt);
        alu_zero         = (alu_lo == 32'h0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] tos;
        int          depth;
        bit          fz, uf, of;
        int          low;
        bit          op_chk;
        logic [31:0] a, b;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] stk[$];
    bit          m_fz, m_uf, m_of;

    task automatic issue(input logic [1:0] t, input logic [31:0] d, input logic [3:0] op,
                         input logic [4:0] sh);
        exp_t        e;
        logic [63:0] r;
        logic [31:0] a, b;
        int          g;
        g = 0;
        while (!cif.cmd_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (!cif.cmd_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout actual=0 expected=1 at %0t", $time);
            return;
        end
        e.low = 0; e.op_chk = 1'b0; e.a = '0; e.b = '0;
        case (t)
            2'b00: if (stk.size() == DEPTH) m_of = 1'b1; else stk.push_back(d);
            2'b01: if (stk.size() == 0) m_uf = 1'b1; else void'(stk.pop_back());
            2'b11: begin stk.delete(); m_uf = 1'b0; m_of = 1'b0; m_fz = 1'b0; end
            default: begin
                if (stk.size() < 2) begin
                    m_uf = 1'b1;
                end else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    r = alu_calc(op, a, b, sh);
                    m_fz = (r[31:0] == 32'h0);
                    e.op_chk = 1'b1; e.a = a; e.b = b; e.low = 1;
                    stk.push_back(r[31:0]);
`ifdef MULT_HI_PUSH_EN
                    if (op == 4'h6 || op == 4'h7) begin
                        stk.push_back(r[63:32]);
                        e.low = 2;
                    end
`endif
                end
            end
        endcase
        e.tos   = (stk.size() > 0) ? stk[$] : 32'h0;
        e.depth = stk.size();
        e.fz = m_fz; e.uf = m_uf; e.of = m_of;
        sbq.push_back(e);
        cif.cmd_valid = 1'b1; cif.cmd_type = t; cif.cmd_data = d;
        cif.cmd_op = op; cif.cmd_shamt = sh;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
    endtask

    // Monitor: tracks one in-flight command; completes it when cmd_ready returns
    bit pend = 1'b0, first = 1'b0;
    int lowc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pend = 1'b0;
            sbq.delete();
        end else begin
            if (pend) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty actual=0 expected=1 at %0t", $time);
                    pend = 1'b0;
                end else if (!cif.cmd_ready) begin
                    if (first && sbq[0].op_chk) begin
                        check("alu_a", alu_a, sbq[0].a);
                        check("alu_b", alu_b, sbq[0].b);
                    end
                    first = 1'b0;
                    lowc++;
                    if (lowc > 5) begin
                        checks++; errors++;
                        $display("FAIL busy_timeout actual=%0d expected<=2 at %0t", lowc, $time);
                        void'(sbq.pop_front());
                        pend = 1'b0;
                    end
                end else begin
                    e = sbq.pop_front();
                    check("tos", tos, e.tos);
                    check("depth", 32'(depth), 32'(e.depth));
                    check("flag_zero", 32'(flag_zero), 32'(e.fz));
                    check("err_underflow", 32'(err_underflow), 32'(e.uf));
                    check("err_overflow", 32'(err_overflow), 32'(e.of));
                    check("ready_low_cycles", 32'(lowc), 32'(e.low));
                    pend = 1'b0;
                end
            end
            if (cif.cmd_valid && cif.cmd_ready) begin
                pend = 1'b1; first = 1'b1; lowc = 0;
            end
        end
    end

    task automatic drain();
        int g;
        g = 0;
        while ((sbq.size() != 0 || pend) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (sbq.size() != 0 || pend) begin
            checks++; errors++;
            $display("FAIL drain actual=%0d expected=0 at %0t", sbq.size(), $time);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=done at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  t;
        logic [31:0] d;
        int          r;
        reset = 1'b1;
        cif.cmd_valid = 1'b0; cif.cmd_type = '0; cif.cmd_data = '0;
        cif.cmd_op = '0; cif.cmd_shamt = '0;
        m_fz = 1'b0; m_uf = 1'b0; m_of = 1'b0;
        #12;
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_tos", tos, 32'h0);
        check("rst_ready", 32'(cif.cmd_ready), 32'd1);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_flags", {29'h0, flag_zero, err_underflow, err_overflow}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        issue(2'b00, 32'd7, 4'h0, 5'd0);
        issue(2'b00, 32'd5, 4'h0, 5'd0);
        issue(2'b10, 32'd0, 4'h4, 5'd0);
        issue(2'b00, 32'd3, 4'h0, 5'd0);
        issue(2'b00, 32'd3, 4'h0, 5'd0);
        issue(2'b10, 32'd0, 4'h5, 5'd0);
        issue(2'b11, 32'd0, 4'h0, 5'd0);
        issue(2'b01, 32'd0, 4'h0, 5'd0);
        issue(2'b00, 32'd4, 4'h0, 5'd0);
        issue(2'b10, 32'd0, 4'h4, 5'd0);
        issue(2'b11, 32'd0, 4'h0, 5'd0);
        for (int i = 1; i <= DEPTH + 1; i++) issue(2'b00, 32'(i), 4'h0, 5'd0);
        issue(2'b11, 32'd0, 4'h0, 5'd0);
        issue(2'b00, 32'h8000_0000, 4'h0, 5'd0);
        issue(2'b00, 32'd4, 4'h0, 5'd0);
        issue(2'b10, 32'd0, 4'h7, 5'd0);
        issue(2'b01, 32'd0, 4'h0, 5'd0);
        issue(2'b11, 32'd0, 4'h0, 5'd0);
        drain();

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            t = (r < 40) ? 2'b00 : (r < 55) ? 2'b01 : (r < 96) ? 2'b10 : 2'b11;
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(t, d, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
        end
        drain();

        issue(2'b11, 32'd0, 4'h0, 5'd0);
        issue(2'b00, 32'd9, 4'h0, 5'd0);
        issue(2'b00, 32'd1, 4'h0, 5'd0);
        drain();
        cif.cmd_valid = 1'b1; cif.cmd_type = 2'b10; cif.cmd_op = 4'h4; cif.cmd_shamt = '0;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        check("exec_ready_low", 32'(cif.cmd_ready), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("midrst_depth", 32'(depth), 32'd0);
        check("midrst_tos", tos, 32'h0);
        check("midrst_ready", 32'(cif.cmd_ready), 32'd1);
        stk.delete(); m_fz = 1'b0; m_uf = 1'b0; m_of = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("postrst_depth", 32'(depth), 32'd0);
        check("postrst_ready", 32'(cif.cmd_ready), 32'd1);
        check("postrst_alu_b", alu_b, 32'h0);
        issue(2'b00, 32'd11, 4'h0, 5'd0);
        issue(2'b00, 32'd2, 4'h0, 5'd0);
        issue(2'b10, 32'd0, 4'h5, 5'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
